// File: rtl/if_id_buf_pkg.sv
// Shared constants for the fetch/decode instruction buffer.
// Optional idle NOP fill is controlled by IF_ID_BUF_NOP_FILL_EN.
package if_id_buf_pkg;

  localparam int PORT_ADDR_WIDTH = 32;
  localparam int PORT_DATA_WIDTH = 32;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Instructions are word aligned; any set low pc bit flags the entry.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_buf_if.sv
// Handshake bundle between fetch, the instruction buffer and decode.
// master = fetch/decode side, slave = the buffer itself.
interface if_id_buf_if #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = if_id_buf_pkg::PORT_ADDR_WIDTH,
  parameter int DATA_W = if_id_buf_pkg::PORT_DATA_WIDTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              inst_valid_i;
  logic [DATA_W-1:0] inst_data_i;
  logic [ADDR_W-1:0] pc_i;
  logic              inst_ready_o;
  logic              flush_i;
  logic              hold_i;
  logic              id_ready_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic              misalign_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output inst_valid_i, inst_data_i, pc_i, flush_i, hold_i, id_ready_i,
    input  inst_ready_o, inst_valid_o, inst_o, pc_o, misalign_o, count_o
  );

  modport slave (
    input  inst_valid_i, inst_data_i, pc_i, flush_i, hold_i, id_ready_i,
    output inst_ready_o, inst_valid_o, inst_o, pc_o, misalign_o, count_o
  );
endinterface

// File: rtl/if_id_buf_sync_fifo_ptr.sv
// Pointer and occupancy controller for the instruction buffer.
// Flush clears everything at the next edge and overrides push/pop.
module sync_fifo_ptr #(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode instruction buffer: small FIFO of {misalign, pc, inst}.
// Define IF_ID_BUF_NOP_FILL_EN to present a NOP instead of zero when empty.
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = PORT_ADDR_WIDTH,
  parameter int DATA_W = PORT_DATA_WIDTH
) (
  input logic           clk,
  input logic           rst,
  if_id_buf_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef IF_ID_BUF_NOP_FILL_EN
  localparam logic [DATA_W-1:0] IDLE_INST = DATA_W'(INST_NOP);
`else
  localparam logic [DATA_W-1:0] IDLE_INST = DATA_W'(ZERO_WORD);
`endif

  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic              mem_mis  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             head_valid;

  assign head_valid = ~empty;
  assign push = bus.inst_valid_i & ~full & ~bus.flush_i;
  assign pop  = head_valid & bus.id_ready_i & ~bus.hold_i & ~bus.flush_i;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (bus.flush_i),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage needs no reset: every read is qualified by head_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= bus.inst_data_i;
      mem_pc[wr_ptr]   <= bus.pc_i;
      mem_mis[wr_ptr]  <= pc_misaligned(bus.pc_i[1:0]);
    end
  end

  assign bus.inst_ready_o = ~full;
  assign bus.inst_valid_o = head_valid;
  assign bus.count_o      = count;
  assign bus.inst_o       = head_valid ? mem_inst[rd_ptr] : IDLE_INST;
  assign bus.pc_o         = head_valid ? mem_pc[rd_ptr] : '0;
  assign bus.misalign_o   = head_valid & mem_mis[rd_ptr];
endmodule
